fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/fetch_ctrl_if.sv | 11 +
 rtl/fetch_timer.sv | 26 ++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch/sequence controller:
// word width, opcodes, PC source encodings, sequencer states and instruction classes.
package cpu_pkg;

  localparam int WORD_W = 24;
  localparam int OPC_W  = 6;

  localparam logic [OPC_W-1:0] OP_JMP  = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OPC_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pc_sel_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, RETRY, DECODE, EXEC, WB, HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_JMP, C_BEQ, C_BNE, C_HALT
  } op_class_t;

  // Anything that is not a control-flow or halt opcode executes on the ALU.
  function automatic op_class_t classify(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_JMP:  return C_JMP;
      OP_BEQ:  return C_BEQ;
      OP_BNE:  return C_BNE;
      OP_HALT: return C_HALT;
      default: return C_ALU;
    endcase
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory fetch bus: the controller issues mem_req, memory returns mem_rdy/mem_data.
interface fetch_ctrl_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_rdy;
  logic [WORD_W-1:0] mem_data;

  modport master (output mem_req, input  mem_rdy, input  mem_data);
  modport slave  (input  mem_req, output mem_rdy, output mem_data);
endinterface

// File: rtl/fetch_timer.sv
// Counts FETCH cycles spent waiting on memory; expired flags the last cycle before a re-issue.
module fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 8'd1;
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction sequencer: FETCH/DECODE/EXEC/WB with fetch timeout retry, stall freeze and HALT.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  fetch_ctrl_if.master       mem,
  input  logic               zero_flag,
  input  logic               stall,
  output logic [WORD_W-1:0]  ir,
  output logic [1:0]         pc_sel,
  output logic               pc_en,
  output logic               alu_en,
  output logic               rf_we,
  output logic               halted,
  output logic               fetch_err,
  output logic [15:0]        retired
);

  state_t    state, state_nx;
  op_class_t cls;
  pc_sel_t   pc_sel_q, pc_sel_wb;
  logic      taken;
  logic      accept, expired, tmr_clear, tmr_en;

  assign cls    = classify(ir[WORD_W-1 -: OPC_W]);
  assign accept = (state == FETCH) && mem.mem_rdy && !stall;

  // The counter only advances while waiting; it stops at its last value so the
  // RETRY cycle sees a clean clear.
  assign tmr_clear = !stall && (accept || (state == RETRY));
  assign tmr_en    = (state == FETCH) && !stall && !mem.mem_rdy && !expired;

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    if (!stall) begin
      case (state)
        IDLE:    state_nx = FETCH;
        FETCH:   if (mem.mem_rdy)  state_nx = DECODE;
                 else if (expired) state_nx = RETRY;
        RETRY:   state_nx = FETCH;
        DECODE:  state_nx = (cls == C_HALT) ? HALT : EXEC;
        EXEC:    state_nx = WB;
        WB:      state_nx = FETCH;
        HALT:    state_nx = HALT;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    pc_sel_wb = PC_SEQ;
    if (cls == C_JMP) pc_sel_wb = PC_JMP;
    else if (taken)   pc_sel_wb = PC_BR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= '0;
      taken    <= 1'b0;
      pc_sel_q <= PC_SEQ;
      retired  <= '0;
    end else begin
      if (accept) ir <= mem.mem_data;
      if (!stall) begin
        if (state == EXEC)
          taken <= ((cls == C_BEQ) && zero_flag) || ((cls == C_BNE) && !zero_flag);
        if (state == WB) begin
          pc_sel_q <= pc_sel_wb;
          retired  <= retired + 16'd1;
        end
      end
    end
  end

  // Moore decode of state; a stall suppresses the strobes but leaves mem_req alone.
  assign mem.mem_req = (state == FETCH);
  assign halted      = (state == HALT);
  assign fetch_err   = (state == RETRY) && !stall;
  assign alu_en      = (state == EXEC) && (cls == C_ALU) && !stall;
  assign pc_en       = (state == WB) && !stall;
  assign rf_we       = pc_en && (cls == C_ALU);
  assign pc_sel      = (state == WB) ? pc_sel_wb : pc_sel_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, ALU/branch/jump flow, timeout retry, stall, halt, wrap.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        zero_flag = 1'b0;
  logic        stall = 1'b0;
  logic [23:0] ir;
  logic [1:0]  pc_sel;
  logic        pc_en, alu_en, rf_we, halted, fetch_err;
  logic [15:0] retired;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_ret = '0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .zero_flag (zero_flag),
    .stall     (stall),
    .ir        (ir),
    .pc_sel    (pc_sel),
    .pc_en     (pc_en),
    .alu_en    (alu_en),
    .rf_we     (rf_we),
    .halted    (halted),
    .fetch_err (fetch_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH, mem_rdy low.
  task automatic enter_fetch;
    rst = 1'b1; stall = 1'b0; zero_flag = 1'b0;
    bus.mem_rdy = 1'b0; bus.mem_data = '0;
    step; step;
    rst = 1'b0; exp_ret = '0;
    step;
  endtask

  // From a FETCH cycle: accept word immediately, drive noise on the bus afterwards,
  // and return in the WB cycle.
  task automatic run_instr(input logic [23:0] word, input logic zf, output logic alu_seen);
    bus.mem_rdy = 1'b1; bus.mem_data = word; zero_flag = zf;
    step;                       // DECODE
    bus.mem_data = ~word;       // mem_rdy still high but must be ignored
    step;                       // EXEC
    alu_seen = alu_en;
    step;                       // WB
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.mem_rdy = 1'b1; bus.mem_data = 24'h123456;
    step; step;
    total++;
    if ({bus.mem_req, pc_en, alu_en, rf_we, halted, fetch_err} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000",
                      {bus.mem_req, pc_en, alu_en, rf_we, halted, fetch_err});
    end
    total++;
    if ({ir, pc_sel, retired} !== 42'b0) begin
      bad++; $display("FAIL reset_regs: ir=%h pc_sel=%b retired=%h want all 0", ir, pc_sel, retired);
    end
    rst = 1'b0; bus.mem_rdy = 1'b0;
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL idle_mem_req: got %b want 0", bus.mem_req);
    end
    step;
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL first_fetch_mem_req: got %b want 1", bus.mem_req);
    end
  endtask

  task automatic test_alu;
    logic a;
    enter_fetch;
    run_instr(24'h000000, 1'b0, a);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL alu_en_cycle3: got %b want 1", a); end
    total++;
    if ({pc_en, rf_we, pc_sel} !== 4'b1100) begin
      bad++; $display("FAIL alu_wb: pc_en,rf_we,pc_sel got %b want 1100", {pc_en, rf_we, pc_sel});
    end
    step; exp_ret++;
    total++;
    if ({retired, pc_en, bus.mem_req} !== {16'd1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL alu_retire: retired=%h pc_en=%b mem_req=%b want 0001 0 1",
                      retired, pc_en, bus.mem_req);
    end
  endtask

  task automatic test_branch;
    logic [23:0] words [4] = '{24'h100005, 24'h100005, 24'h140000, 24'h140000};
    logic        zfs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sels  [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
    logic        a;
    for (int i = 0; i < 4; i++) begin
      run_instr(words[i], zfs[i], a);
      total++;
      if ({pc_sel, pc_en, rf_we, a} !== {sels[i], 3'b100}) begin
        bad++; $display("FAIL branch_wb[%0d]: pc_sel,pc_en,rf_we,alu got %b want %b",
                        i, {pc_sel, pc_en, rf_we, a}, {sels[i], 3'b100});
      end
      total++;
      if (ir !== words[i]) begin
        bad++; $display("FAIL branch_ir[%0d]: got %h want %h", i, ir, words[i]);
      end
      step; exp_ret++;
      total++;
      if ({pc_sel, retired} !== {sels[i], exp_ret}) begin
        bad++; $display("FAIL branch_hold[%0d]: pc_sel=%b retired=%h want %b %h",
                        i, pc_sel, retired, sels[i], exp_ret);
      end
    end
  endtask

  task automatic test_timeout;
    int errs = 0, low_req = 0, err_at = -1;
    for (int i = 0; i < 19; i++) begin
      step;
      if (fetch_err) begin errs++; err_at = i; end
      if (!bus.mem_req) low_req++;
    end
    total++;
    if (errs !== 1 || err_at !== 14) begin
      bad++; $display("FAIL timeout_err: pulses=%0d at=%0d want 1 at 14", errs, err_at);
    end
    total++;
    if (low_req !== 1 || bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL timeout_retry_req: low cycles=%0d now=%b want 1 and 1", low_req, bus.mem_req);
    end
    bus.mem_rdy = 1'b1; bus.mem_data = 24'h000123;
    step;
    bus.mem_rdy = 1'b0;
    total++;
    if ({ir, bus.mem_req} !== {24'h000123, 1'b0}) begin
      bad++; $display("FAIL timeout_accept: ir=%h mem_req=%b want 000123 0", ir, bus.mem_req);
    end
    step; step;
    total++;
    if (pc_en !== 1'b1) begin bad++; $display("FAIL timeout_wb: pc_en got %b want 1", pc_en); end
    step; exp_ret++;
  endtask

  task automatic test_tie;
    int errs = 0;
    for (int i = 0; i < 14; i++) begin
      step;
      if (fetch_err) errs++;
    end
    bus.mem_rdy = 1'b1; bus.mem_data = 24'h000000;
    step;
    bus.mem_rdy = 1'b0;
    if (fetch_err) errs++;
    total++;
    if (errs !== 0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL tie_rdy_wins: fetch_err pulses=%0d mem_req=%b want 0 0", errs, bus.mem_req);
    end
    step; step; step; exp_ret++;
    total++;
    if (retired !== exp_ret) begin
      bad++; $display("FAIL tie_retire: got %h want %h", retired, exp_ret);
    end
  endtask

  task automatic test_stall_wb;
    int pulses = 0;
    bus.mem_rdy = 1'b1; bus.mem_data = 24'h000007;
    step;
    bus.mem_rdy = 1'b0;
    step; step;                 // WB
    stall = 1'b1; #1;
    if (pc_en) pulses++;
    step; if (pc_en) pulses++;
    step; if (pc_en) pulses++;
    total++;
    if ({pulses, retired} !== {32'd0, exp_ret}) begin
      bad++; $display("FAIL stall_hold: pc_en pulses=%0d retired=%h want 0 %h", pulses, retired, exp_ret);
    end
    stall = 1'b0; #1;
    total++;
    if ({pc_en, rf_we} !== 2'b11) begin
      bad++; $display("FAIL stall_release: pc_en,rf_we got %b want 11", {pc_en, rf_we});
    end
    if (pc_en) pulses++;
    step; if (pc_en) pulses++;
    exp_ret++;
    total++;
    if (pulses !== 1 || retired !== exp_ret) begin
      bad++; $display("FAIL stall_once: pulses=%0d retired=%h want 1 %h", pulses, retired, exp_ret);
    end
  endtask

  task automatic test_jmp;
    logic a;
    run_instr(24'h08ABCD, 1'b0, a);
    total++;
    if ({pc_sel, pc_en, rf_we, a} !== 5'b10100) begin
      bad++; $display("FAIL jmp_wb: pc_sel,pc_en,rf_we,alu got %b want 10100", {pc_sel, pc_en, rf_we, a});
    end
    step; exp_ret++;
    total++;
    if ({pc_sel, pc_en} !== 3'b100) begin
      bad++; $display("FAIL jmp_after: pc_sel,pc_en got %b want 100", {pc_sel, pc_en});
    end
  endtask

  task automatic test_reset_exec;
    int strobes = 0;
    bus.mem_rdy = 1'b1; bus.mem_data = 24'h000042;
    step;
    bus.mem_rdy = 1'b0;
    step;                       // EXEC
    total++;
    if (alu_en !== 1'b1) begin bad++; $display("FAIL rexec_alu: got %b want 1", alu_en); end
    rst = 1'b1; #1;
    total++;
    if ({bus.mem_req, pc_en, alu_en, rf_we, halted, fetch_err, pc_sel, ir, retired} !== 48'b0) begin
      bad++; $display("FAIL rexec_async: strobes=%b pc_sel=%b ir=%h retired=%h want all 0",
                      {bus.mem_req, pc_en, alu_en, rf_we, halted, fetch_err}, pc_sel, ir, retired);
    end
    step; if (pc_en || rf_we) strobes++;
    step; if (pc_en || rf_we) strobes++;
    rst = 1'b0; exp_ret = '0;
    if (pc_en || rf_we) strobes++;
    step; if (pc_en || rf_we) strobes++;
    total++;
    if (strobes !== 0 || bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL rexec_no_wb: strobes=%0d mem_req=%b want 0 1", strobes, bus.mem_req);
    end
  endtask

  task automatic test_wrap;
    logic a;
    // Backdoor preload of the counter in place of 65535 real retirements.
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    #1;
    total++;
    if (retired !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", retired); end
    run_instr(24'h000000, 1'b0, a);
    step;
    total++;
    if (retired !== 16'h0000) begin bad++; $display("FAIL wrap: got %h want 0000", retired); end
    exp_ret = 16'h0000;
  endtask

  task automatic test_halt;
    int activity = 0;
    bus.mem_rdy = 1'b1; bus.mem_data = 24'hFC0000;
    step;
    bus.mem_rdy = 1'b0;
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL halt_decode: halted got %b want 0", halted); end
    step;
    total++;
    if ({halted, bus.mem_req, pc_en, alu_en} !== 4'b1000) begin
      bad++; $display("FAIL halt_enter: halted,mem_req,pc_en,alu_en got %b want 1000",
                      {halted, bus.mem_req, pc_en, alu_en});
    end
    for (int i = 0; i < 8; i++) begin
      bus.mem_rdy = i[0]; bus.mem_data = 24'h000000;
      step;
      if (bus.mem_req || pc_en || alu_en || rf_we || !halted) activity++;
    end
    total++;
    if (activity !== 0 || retired !== exp_ret) begin
      bad++; $display("FAIL halt_stay: bad cycles=%0d retired=%h want 0 %h", activity, retired, exp_ret);
    end
  endtask

  initial begin
    bus.mem_rdy = 1'b0; bus.mem_data = '0;
    test_reset;
    test_alu;
    test_branch;
    test_timeout;
    test_tie;
    test_stall_wb;
    test_jmp;
    test_reset_exec;
    test_wrap;
    test_halt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
